// File: rtl/fp_pkg.sv
// fp_pkg: binary32 field widths, bias, special encodings and the state
// encoding of the serial integer-to-float converter. The multiplier
// result-export stage uses the same definitions.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam logic [31:0] FP_QNAN    = 32'h7FFF_FFFF;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    NORM  = ST_NORM,
    ROUND = ST_ROUND,
    DONE  = ST_DONE
  } conv_state_t;

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational round-to-nearest-even and pack of a
// normalised 32-bit magnitude into a binary32 word.
//   sign     in   1   result sign
//   exp      in   8   biased exponent matching mag[31]
//   mag      in   32  normalised magnitude (mag[31] is the hidden bit)
//   fp       out  32  {sign, exp, man}
//   inexact  out  1   guard or sticky bit nonzero
module fp_round_pack
  import fp_pkg::*;
(
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [31:0] mag,
  output logic [31:0] fp,
  output logic        inexact
);

  logic [FP_MAN_W-1:0] man;
  logic                guard;
  logic                sticky;
  logic                rnd;
  logic [FP_MAN_W:0]   man_sum;
  logic [7:0]          exp_out;

  assign man    = mag[30:8];
  assign guard  = mag[7];
  assign sticky = |mag[6:0];
  // Ties go to the even mantissa: only round up on a tie when man is odd.
  assign rnd    = guard & (sticky | man[0]);

  // A carry out of the mantissa leaves man_sum[22:0] all zero, which is
  // exactly the renormalised mantissa; the exponent absorbs the carry.
  assign man_sum = {1'b0, man} + {{FP_MAN_W{1'b0}}, rnd};
  assign exp_out = exp + {7'd0, man_sum[FP_MAN_W]};

  assign fp      = {sign, exp_out, man_sum[FP_MAN_W-1:0]};
  assign inexact = guard | sticky;

endmodule

// File: rtl/int_to_fp_convert.sv
// int_to_fp_convert: serial integer to IEEE754 binary32 converter.
// Normalises one bit per cycle, then rounds to nearest-even.
//   clk          in   1   rising-edge clock
//   rst_n        in   1   synchronous active-low reset
//   in_valid     in   1   in_int / in_signed valid
//   in_ready     out  1   converter idle, can accept
//   in_int       in   32  integer operand
//   in_signed    in   1   1: two's complement, 0: unsigned
//   out_valid    out  1   out_fp valid, held until out_ready
//   out_ready    in   1   consumer accepts result
//   out_fp       out  32  binary32 result
//   out_inexact  out  1   result was rounded
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its data until that edge.
module int_to_fp_convert
  import fp_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_int,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_fp,
  output logic             out_inexact
);

  // Exponent of a value whose leading one sits in bit INT_W-1.
  localparam logic [7:0] EXP_PRELOAD = 8'(FP_BIAS + INT_W - 1);

  conv_state_t      state, state_d;
  logic [INT_W-1:0] mag, mag_d;
  logic [7:0]       exp, exp_d;
  logic             sign, sign_d;
  logic [31:0]      fp_q, fp_d;
  logic             inexact_q, inexact_d;

  logic             in_sign;
  logic [INT_W-1:0] in_mag;
  logic [31:0]      rp_fp;
  logic             rp_inexact;

  // Negating 0x80000000 wraps back to 0x80000000, the correct magnitude.
  assign in_sign = in_signed & in_int[INT_W-1];
  assign in_mag  = in_sign ? (~in_int + 1'b1) : in_int;

  fp_round_pack u_round_pack (
    .sign    (sign),
    .exp     (exp),
    .mag     (mag),
    .fp      (rp_fp),
    .inexact (rp_inexact)
  );

  assign in_ready    = (state == IDLE) & rst_n;
  assign out_valid   = (state == DONE);
  assign out_fp      = fp_q;
  assign out_inexact = inexact_q;

  always_comb begin
    state_d   = state;
    mag_d     = mag;
    exp_d     = exp;
    sign_d    = sign;
    fp_d      = fp_q;
    inexact_d = inexact_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          mag_d  = in_mag;
          exp_d  = EXP_PRELOAD;
          if (in_mag == '0) begin
            // Zero is always +0, even for a signed input.
            fp_d      = FP_ZERO;
            inexact_d = 1'b0;
            state_d   = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag[INT_W-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag << 1;
          exp_d = exp - 8'd1;
        end
      end
      ROUND: begin
        fp_d      = rp_fp;
        inexact_d = rp_inexact;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      exp       <= '0;
      sign      <= 1'b0;
      fp_q      <= FP_ZERO;
      inexact_q <= 1'b0;
    end else begin
      state     <= state_d;
      mag       <= mag_d;
      exp       <= exp_d;
      sign      <= sign_d;
      fp_q      <= fp_d;
      inexact_q <= inexact_d;
    end
  end

endmodule

// File: tb/tb_int_to_fp_convert.sv
module tb_int_to_fp_convert;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_int;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fp;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  int_to_fp_convert dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_int      (in_int),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fp      (out_fp),
    .out_inexact (out_inexact)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  // Drives one operand, measures latency, checks result, optionally stalls
  // the consumer for `hold` cycles, then completes the output transfer.
  task automatic convert(input string tag, input logic [31:0] v, input logic sg,
                         input logic [31:0] want_fp, input logic want_inx,
                         input int want_lat, input int hold);
    int cyc;
    logic [31:0] first_fp;
    @(negedge clk);
    in_int    = v;
    in_signed = sg;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    exp_q.push_back(want_fp);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_int    = $urandom;
    in_signed = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, cyc, want_lat);
    check({tag, ".fp"}, out_fp, exp_q.pop_front());
    check({tag, ".inexact"}, {31'd0, out_inexact}, {31'd0, want_inx});
    first_fp = out_fp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_fp"}, out_fp, first_fp);
      check({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".post_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_int    = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", {31'd0, in_ready}, 32'd0);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_fp", out_fp, 32'h0000_0000);
    check("rst.inexact", {31'd0, out_inexact}, 32'd0);
    rst_n = 1'b1;

    //      tag          value         sgn   expected       inx   lat  hold
    convert("zero_s",    32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1,  0);
    convert("m1_s",      32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 34, 0);
    convert("max_u",     32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3,  0);
    convert("min_s",     32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3,  0);
    convert("tie_even",  32'd16777217,  1'b0, 32'h4B80_0000, 1'b1, 10, 0);
    convert("tie_up",    32'd16777219,  1'b0, 32'h4B80_0002, 1'b1, 10, 0);
    convert("one_u",     32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 34, 0);
    convert("five_s",    32'h0000_0005, 1'b1, 32'h40A0_0000, 1'b0, 32, 0);
    convert("m100_s",    32'hFFFF_FF9C, 1'b1, 32'hC2C8_0000, 1'b0, 28, 0);
    convert("maxpos_s",  32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 1'b1, 4,  0);
    convert("stall",     32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3,  5);

    // Reset in the middle of normalisation discards the conversion.
    @(negedge clk);
    in_int    = 32'h0000_0001;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst.in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst.out_fp", out_fp, 32'h0000_0000);
    rst_n = 1'b1;
    convert("after_rst", 32'h0000_0003, 1'b0, 32'h4040_0000, 1'b0, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
